dst_xbar: RTL and testbench
===========================

# dst_xbar

Handshaked, registered crossbar where each input names its destination output. It is the source-routed counterpart of the output-select `xbar`: there, each output picks an input. Here, each input requests an output, conflicting requests are arbitrated per output, and each output holds one registered beat with valid/ready backpressure. It sits between NUM_ELEM producer lanes and NUM_ELEM consumer lanes wherever routing is decided by the sender.

## Interface
- `ELEM_WIDTH`, 8, width of each data element
- `NUM_ELEM`, 6, number of input lanes and output lanes (≥2)
- `clk_i`  in  1  clock, all state updates on the rising edge
- `arst_ni`  in  1  asynchronous active-low reset
- `s_valid_i`  in  NUM_ELEM  input lane i holds a beat
- `s_dst_i`  in  NUM_ELEM×$clog2(NUM_ELEM)  destination output index per input lane
- `s_data_i`  in  NUM_ELEM×ELEM_WIDTH  data per input lane
- `s_ready_o`  out  NUM_ELEM  input lane i's beat is accepted this cycle
- `m_valid_o`  out  NUM_ELEM  output lane j holds a beat
- `m_data_o`  out  NUM_ELEM×ELEM_WIDTH  data per output lane
- `m_src_o`  out  NUM_ELEM×$clog2(NUM_ELEM)  input index that produced the held beat
- `m_ready_i`  in  NUM_ELEM  consumer on output lane j takes the beat

## Operation
- **Destination normalisation.**
  - When NUM_ELEM is not a power of two: dst' = dst when dst < NUM_ELEM, otherwise dst − NUM_ELEM. For example, with NUM_ELEM=6, dst 6→0 and dst 7→1.
  - When NUM_ELEM is a power of two: dst' = dst.
- **Request.** `req[j][i]` = `s_valid_i[i]` && dst'(i) == j. Each input requests exactly one output.
- **Output slot.** Output j has one register slot. The slot can load when `!m_valid_o[j] || m_ready_i[j]`.
- **Grant.** When output j can load and has at least one request, exactly one requester i is granted (see Configuration). No grant is issued when the slot cannot load.
- **Ready.** `s_ready_o[i]` = 1 when input i is granted by its destination. This is combinational from `s_valid_i`, `s_dst_i`, `m_valid_o` and `m_ready_i`. `s_ready_o[i]` is 0 whenever `s_valid_i[i]`=0.
- **Load.** On a grant, output j's slot captures data_i and src=i, and `m_valid_o[j]` ← 1.
- **Drain.** When `m_valid_o[j] && m_ready_i[j]` and there is no grant, `m_valid_o[j]` ← 0. Data and src hold their last value.
- **Simultaneous drain and grant.** The slot is replaced in the same cycle, so a lane sustains 1 beat per cycle.
- **Stability.** While `m_valid_o[j] && !m_ready_i[j]`, `m_data_o[j]` and `m_src_o[j]` are stable.
- **Input handshake rules.** A beat transfers only when `s_valid_i[i] && s_ready_o[i]`. The producer holds valid, dst and data stable until that transfer.
- **Independence.** Distinct outputs are independent, so up to NUM_ELEM beats transfer per cycle.

## Timing
- **Reset values.** `arst_ni`=0 asynchronously clears:
  - `m_valid_o`=0, `m_data_o`=0, `m_src_o`=0
  - all arbitration pointers = 0
- **Reset mid-operation.** Held beats are discarded. `s_ready_o` is 0 while in reset.
- **Latency.** An input handshake in cycle N gives `m_valid_o` high in cycle N+1.
- **No combinational input-to-output data path.** The only combinational path is valid/ready (`s_valid_i`/`s_dst_i`/`m_ready_i` → `s_ready_o`).
- **Full slot.** Output j full with `m_ready_i[j]`=0 gives `s_ready_o`=0 for every input targeting j. Inputs targeting other outputs are unaffected.

## Configuration
- **Macro `DST_XBAR_RR_EN`.**
- **Defined: round-robin arbitration.**
  - Output j keeps a pointer `ptr[j]`.
  - The grant goes to the first requester found scanning indices ptr[j], ptr[j]+1, … modulo NUM_ELEM.
  - On each grant to input g, `ptr[j]` ← (g+1) mod NUM_ELEM. With no grant, `ptr[j]` holds.
  - With all inputs continuously targeting j, each input is served once every NUM_ELEM grants.
- **Undefined: fixed-priority arbitration.**
  - The lowest-index requester wins.
  - No pointer registers are implemented.

## Test plan
(All scenarios use NUM_ELEM=6, ELEM_WIDTH=8.)
- **Reset and single beat.**
  - Stimulus: assert reset, release it, then drive input 2 with dst=4, data=0xA5, `m_ready_i`=0x3F.
  - Required response: `s_ready_o[2]`=1 in the same cycle. Next cycle `m_valid_o[4]`=1, `m_data_o[4]`=0xA5, `m_src_o[4]`=2. All other outputs stay 0.
- **Permutation.**
  - Stimulus: inputs 0..5 all valid with dst={5,4,3,2,1,0}, data=0x10+i, `m_ready_i`=0x3F.
  - Required response: all `s_ready_o`=1. Next cycle `m_data_o[5-i]`=0x10+i for every i.
- **Contention.**
  - Stimulus: inputs 1, 3 and 5 continuously valid with dst=0, `m_ready_i[0]`=1.
  - Required response with `DST_XBAR_RR_EN`: grants in order 1, 3, 5, 1, one per cycle.
  - Required response without the macro: input 1 is granted every cycle.
- **Backpressure.**
  - Stimulus: output 2 loaded with 0x77, then `m_ready_i[2]`=0 for 4 cycles while input 0 targets dst=2 with 0x88.
  - Required response: `m_data_o[2]`=0x77 is stable and `s_ready_o[0]`=0 for those 4 cycles. When `m_ready_i[2]` rises, `s_ready_o[0]`=1 in that cycle and `m_data_o[2]`=0x88 next cycle, with no bubble.
- **Destination wrap.**
  - Stimulus: input 3 sends dst=7 with data 0x3C.
  - Required response: the beat appears on output 1 with `m_src_o[1]`=3.
- **Reset mid-traffic.**
  - Stimulus: `arst_ni` pulsed low while outputs 0..5 are valid and stalled.
  - Required response: `m_valid_o`=0 immediately without waiting for a clock edge. Afterwards round-robin restarts from pointer 0, so input 0 wins first when inputs 0 and 4 contend.

Source files
------------

// File: rtl/dst_xbar_if.sv
// dst_xbar bus bundle: producer-side (s_*) and consumer-side (m_*) lanes.
// The slave modport is the crossbar's own view of the bus; the master
// modport is the view of whatever drives producers and consumes outputs.
interface dst_xbar_if #(
   parameter int ELEM_WIDTH = 8,
   parameter int NUM_ELEM   = 6
);
   localparam int IW = $clog2(NUM_ELEM);

   logic [NUM_ELEM-1:0]                 s_valid_i;
   logic [NUM_ELEM-1:0][IW-1:0]         s_dst_i;
   logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] s_data_i;
   logic [NUM_ELEM-1:0]                 s_ready_o;
   logic [NUM_ELEM-1:0]                 m_valid_o;
   logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] m_data_o;
   logic [NUM_ELEM-1:0][IW-1:0]         m_src_o;
   logic [NUM_ELEM-1:0]                 m_ready_i;

   modport slave (
      input  s_valid_i, s_dst_i, s_data_i, m_ready_i,
      output s_ready_o, m_valid_o, m_data_o, m_src_o
   );

   modport master (
      output s_valid_i, s_dst_i, s_data_i, m_ready_i,
      input  s_ready_o, m_valid_o, m_data_o, m_src_o
   );
endinterface

// File: rtl/dst_xbar.sv
// dst_xbar: source-routed registered crossbar. Every input names the output
// it wants; each output arbitrates among its requesters and holds one beat.
// Define DST_XBAR_RR_EN for per-output round-robin arbitration; without it
// the lowest-index requester wins and no pointer state exists.
module dst_xbar #(
   parameter int ELEM_WIDTH = 8,
   parameter int NUM_ELEM   = 6
) (
   input  logic      clk_i,
   input  logic      arst_ni,
   dst_xbar_if.slave bus
);
   localparam int          IW      = $clog2(NUM_ELEM);
   localparam bit          POW2    = ((1 << IW) == NUM_ELEM);
   localparam logic [IW:0] NUM_EXT = (IW+1)'(NUM_ELEM);

   logic [NUM_ELEM-1:0][IW-1:0]         dst_n;
   logic [NUM_ELEM-1:0]                 can_load;
   logic [NUM_ELEM-1:0]                 gnt_any;
   logic [NUM_ELEM-1:0][IW-1:0]         gnt_idx;
   logic [NUM_ELEM-1:0]                 s_ready;
   logic [NUM_ELEM-1:0]                 m_valid_q;
   logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] m_data_q;
   logic [NUM_ELEM-1:0][IW-1:0]         m_src_q;
`ifdef DST_XBAR_RR_EN
   logic [NUM_ELEM-1:0][IW-1:0]         ptr_q;
`endif

   // Fold destination codes past the last lane back into range (6->0, 7->1).
   always_comb begin
      logic [IW:0] d;
      d     = '0;
      dst_n = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         d = {1'b0, bus.s_dst_i[i]};
         if (!POW2 && d >= NUM_EXT)
            d = d - NUM_EXT;
         dst_n[i] = d[IW-1:0];
      end
   end

   // A slot can take a new beat when empty or being drained; nothing loads in reset.
   assign can_load = (~m_valid_q | bus.m_ready_i) & {NUM_ELEM{arst_ni}};

   // Per-output arbitration: scan inputs from the start index, first requester wins.
   always_comb begin
      int          idx;
      int          start;
      logic [IW-1:0] sel;
      gnt_any = '0;
      gnt_idx = '0;
      idx     = 0;
      start   = 0;
      sel     = '0;
      for (int j = 0; j < NUM_ELEM; j++) begin
`ifdef DST_XBAR_RR_EN
         start = int'(ptr_q[j]);
`else
         start = 0;
`endif
         for (int k = 0; k < NUM_ELEM; k++) begin
            idx = start + k;
            if (idx >= NUM_ELEM)
               idx = idx - NUM_ELEM;
            sel = IW'(idx);
            if (can_load[j] && !gnt_any[j] && bus.s_valid_i[sel] && dst_n[sel] == IW'(j)) begin
               gnt_any[j] = 1'b1;
               gnt_idx[j] = sel;
            end
         end
      end
   end

   // An input is ready exactly when its destination granted it.
   always_comb begin
      s_ready = '0;
      for (int i = 0; i < NUM_ELEM; i++)
         s_ready[i] = bus.s_valid_i[i] && gnt_any[dst_n[i]] && (gnt_idx[dst_n[i]] == IW'(i));
   end

   // Output slots: load on grant (replacing a draining beat), clear valid on plain drain.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         m_valid_q <= '0;
         m_data_q  <= '0;
         m_src_q   <= '0;
      end else begin
         for (int j = 0; j < NUM_ELEM; j++) begin
            if (gnt_any[j]) begin
               m_valid_q[j] <= 1'b1;
               m_data_q[j]  <= bus.s_data_i[gnt_idx[j]];
               m_src_q[j]   <= gnt_idx[j];
            end else if (bus.m_ready_i[j]) begin
               m_valid_q[j] <= 1'b0;
            end
         end
      end
   end

`ifdef DST_XBAR_RR_EN
   // Round-robin pointer moves just past the winner; it holds when nobody is granted.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         ptr_q <= '0;
      end else begin
         for (int j = 0; j < NUM_ELEM; j++) begin
            if (gnt_any[j])
               ptr_q[j] <= (gnt_idx[j] == IW'(NUM_ELEM - 1)) ? '0 : gnt_idx[j] + IW'(1);
         end
      end
   end
`endif

   assign bus.s_ready_o = s_ready;
   assign bus.m_valid_o = m_valid_q;
   assign bus.m_data_o  = m_data_q;
   assign bus.m_src_o   = m_src_q;

endmodule

// File: tb/tb_dst_xbar.sv
// Scoreboard bench for dst_xbar (NUM_ELEM=6, ELEM_WIDTH=8). Stimulus pushes
// the expected {src,data} for each accepted beat onto its output's queue; a
// negedge monitor pops and compares whenever an output beat is handed off.
module tb_dst_xbar;
   localparam int EW = 8;
   localparam int NE = 6;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   dst_xbar_if #(.ELEM_WIDTH(EW), .NUM_ELEM(NE)) bus ();

   dst_xbar #(.ELEM_WIDTH(EW), .NUM_ELEM(NE)) dut (
      .clk_i   (clk),
      .arst_ni (arst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic [10:0]         expq [NE][$];
   logic [5:0]          v;
   logic [5:0][2:0]     d;
   logic [5:0][7:0]     dt;
   logic [5:0]          mr;

   function automatic logic [2:0] norm(input logic [2:0] x);
      return (x >= 3'd6) ? x - 3'd6 : x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // drive the staged vectors just after a rising edge, then check ready and
   // record the beats the design is expected to accept this cycle
   task automatic step(input logic [5:0] exp_rdy, input string nm);
      @(posedge clk);
      #1;
      bus.s_valid_i = v;
      bus.s_dst_i   = d;
      bus.s_data_i  = dt;
      bus.m_ready_i = mr;
      #1;
      chk(nm, 32'(bus.s_ready_o), 32'(exp_rdy));
      for (int i = 0; i < NE; i++)
         if (exp_rdy[i])
            expq[norm(d[i])].push_back({3'(i), dt[i]});
   endtask

   // output-side monitor: every handed-off beat must match the queue head
   always @(negedge clk) begin
      if (arst_n) begin
         for (int j = 0; j < NE; j++) begin
            if (bus.m_valid_o[j] && bus.m_ready_i[j]) begin
               if (expq[j].size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL out%0d_unexpected: got beat %0h expected none", j, bus.m_data_o[j]);
               end else begin
                  logic [10:0] e;
                  e = expq[j].pop_front();
                  chk($sformatf("out%0d_beat", j), 32'({bus.m_src_o[j], bus.m_data_o[j]}), 32'(e));
               end
            end
         end
      end
   end

   initial begin
      logic [5:0] cont_exp [4];
      int         qtot;

`ifdef DST_XBAR_RR_EN
      cont_exp = '{6'b000010, 6'b001000, 6'b100000, 6'b000010};
`else
      cont_exp = '{6'b000010, 6'b000010, 6'b000010, 6'b000010};
`endif
      v  = '0;
      d  = '0;
      dt = '0;
      mr = '1;
      bus.s_valid_i = '0;
      bus.s_dst_i   = '0;
      bus.s_data_i  = '0;
      bus.m_ready_i = '1;

      // reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_m_valid", 32'(bus.m_valid_o), 32'h0);
      chk("rst_m_data_nz", 32'(bus.m_data_o != '0), 32'h0);
      chk("rst_m_src", 32'(bus.m_src_o), 32'h0);
      bus.s_valid_i = 6'h3F;
      #1;
      chk("rst_s_ready", 32'(bus.s_ready_o), 32'h0);
      bus.s_valid_i = '0;
      #1;
      arst_n = 1'b1;

      // single beat: input 2 -> output 4
      v = 6'b000100; d[2] = 3'd4; dt[2] = 8'hA5;
      step(6'b000100, "single_ready");
      v = '0;
      step(6'b0, "single_idle");
      chk("single_valid", 32'(bus.m_valid_o), 32'h10);

      // permutation: input i -> output 5-i
      for (int i = 0; i < NE; i++) begin
         d[i]  = 3'(5 - i);
         dt[i] = 8'(16 + i);
      end
      v = 6'h3F;
      step(6'h3F, "perm_ready");
      v = '0;
      step(6'b0, "perm_idle");
      chk("perm_valid", 32'(bus.m_valid_o), 32'h3F);

      // destination wrap: dst 7 lands on output 1
      v = 6'b001000; d[3] = 3'd7; dt[3] = 8'h3C;
      step(6'b001000, "wrap_ready");
      v = '0;
      step(6'b0, "wrap_idle");
      chk("wrap_valid", 32'(bus.m_valid_o), 32'h02);

      // backpressure on output 2
      v = 6'b000010; d[1] = 3'd2; dt[1] = 8'h77; mr = 6'b111011;
      step(6'b000010, "bp_load");
      v = 6'b000001; d[0] = 3'd2; dt[0] = 8'h88;
      for (int c = 0; c < 4; c++) begin
         step(6'b0, "bp_stall_ready");
         chk("bp_stall_data", 32'(bus.m_data_o[2]), 32'h77);
         chk("bp_stall_valid", 32'(bus.m_valid_o[2]), 32'h1);
      end
      mr = '1;
      step(6'b000001, "bp_release_ready");
      v = '0;
      step(6'b0, "bp_idle");
      chk("bp_nobubble", 32'({bus.m_valid_o[2], bus.m_data_o[2]}), 32'h188);
      step(6'b0, "drain0");
      step(6'b0, "drain1");
      qtot = 0;
      for (int j = 0; j < NE; j++) qtot += expq[j].size();
      chk("drained_before_contention", 32'(qtot), 32'h0);

      // fresh pointers before contention
      #1 arst_n = 1'b0;
      #1 arst_n = 1'b1;

      // contention: inputs 1,3,5 all target output 0
      v = 6'b101010;
      d[1] = 3'd0; d[3] = 3'd0; d[5] = 3'd0;
      dt[1] = 8'h51; dt[3] = 8'h53; dt[5] = 8'h55;
      for (int c = 0; c < 4; c++)
         step(cont_exp[c], $sformatf("cont_ready%0d", c));
      v = '0;
      repeat (3) step(6'b0, "cont_idle");

      // reset mid-traffic with every output full and stalled
      for (int i = 0; i < NE; i++) begin
         d[i]  = 3'(i);
         dt[i] = 8'(8'h60 + i);
      end
      v = 6'h3F; mr = '0;
      step(6'h3F, "mid_load");
      v = '0;
      step(6'b0, "mid_hold");
      chk("mid_valid_full", 32'(bus.m_valid_o), 32'h3F);
      #1 arst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.m_valid_o), 32'h0);
      bus.s_valid_i = 6'b000001;
      #1;
      chk("mid_rst_ready", 32'(bus.s_ready_o), 32'h0);
      bus.s_valid_i = '0;
      for (int j = 0; j < NE; j++) expq[j].delete();
      #1 arst_n = 1'b1;

      // after reset input 0 beats input 4 for output 3
      mr = '1;
      v = 6'b010001; d[0] = 3'd3; d[4] = 3'd3; dt[0] = 8'hA0; dt[4] = 8'hA4;
      step(6'b000001, "mid_first");
      v = 6'b010000;
      step(6'b010000, "mid_second");
      v = '0;
      repeat (3) step(6'b0, "final_idle");

      for (int j = 0; j < NE; j++)
         chk($sformatf("final_q%0d_empty", j), 32'(expq[j].size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
